// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART message constants, state encoding and checksum helper
package uart_pkg;

    localparam int BYTE_SIZE_DEFAULT = 8;

    // Encoding is shared with the RX message decoder; keep values stable.
    typedef logic [2:0] msg_state_t;

    localparam msg_state_t ST_IDLE = 3'd0;
    localparam msg_state_t ST_OPT  = 3'd1;
    localparam msg_state_t ST_LEN  = 3'd2;
    localparam msg_state_t ST_DATA = 3'd3;
    localparam msg_state_t ST_DONE = 3'd4;
    localparam msg_state_t ST_CSUM = 3'd5;

    function automatic logic [BYTE_SIZE_DEFAULT-1:0] csum_xor(
        input logic [BYTE_SIZE_DEFAULT-1:0] acc,
        input logic [BYTE_SIZE_DEFAULT-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_idx
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_SIZE = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_SIZE-1:0] last_idx,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [IDX_SIZE-1:0] idx
);

    logic                found;
    logic [IDX_SIZE-1:0] cand;

    // Scan last_idx+1 .. last_idx+NUM_REQ so the previous winner is checked last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_SIZE'((int'(last_idx) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_msg_tx_arb.sv
// rtl/uart_msg_tx_arb.sv - round-robin opt/len/payload framer onto one UART TX byte stream
// Optional trailing XOR checksum byte: UART_MSG_TX_ARB_CHECKSUM_EN
module uart_msg_tx_arb
    import uart_pkg::*;
#(
    parameter int BYTE_SIZE = BYTE_SIZE_DEFAULT,
    parameter int NUM_REQ   = 4,
    parameter int IDX_SIZE  = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BYTE_SIZE-1:0]   req_opt,
    input  logic [NUM_REQ*BYTE_SIZE-1:0]   req_len,
    input  logic [NUM_REQ*BYTE_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_pop,
    output logic [NUM_REQ-1:0]             o_done,
    output logic [BYTE_SIZE-1:0]           tx_byte,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           o_busy
);

    msg_state_t          state;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_SIZE-1:0] gnt_idx;
    logic [IDX_SIZE-1:0] last_idx;
    logic [IDX_SIZE-1:0] arb_idx;
    logic [BYTE_SIZE-1:0] opt_q;
    logic [BYTE_SIZE-1:0] len_q;
    logic [BYTE_SIZE-1:0] cnt;
    logic [BYTE_SIZE-1:0] cur_data;
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] acc;
    localparam msg_state_t ST_TAIL = ST_CSUM;
`else
    localparam msg_state_t ST_TAIL = ST_DONE;
`endif

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_SIZE (IDX_SIZE)
    ) u_rr_arbiter (
        .req      (req),
        .last_idx (last_idx),
        .gnt      (arb_gnt),
        .idx      (arb_idx)
    );

    assign cur_data = req_data[gnt_idx*BYTE_SIZE +: BYTE_SIZE];
    assign o_busy   = (state != ST_IDLE);
    assign o_gnt    = gnt_q;
    assign o_pop    = (state == ST_DATA && tx_ready) ? gnt_q : '0;
    assign o_done   = (state == ST_DONE) ? gnt_q : '0;

    always_comb begin
        tx_valid = 1'b1;
        tx_byte  = '0;
        case (state)
            ST_OPT:  tx_byte = opt_q;
            ST_LEN:  tx_byte = len_q;
            ST_DATA: tx_byte = cur_data;
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
            ST_CSUM: tx_byte = acc;
`endif
            default: tx_valid = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            gnt_idx  <= '0;
            last_idx <= IDX_SIZE'(NUM_REQ - 1);
            opt_q    <= '0;
            len_q    <= '0;
            cnt      <= '0;
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q   <= arb_gnt;
                        gnt_idx <= arb_idx;
                        opt_q   <= req_opt[arb_idx*BYTE_SIZE +: BYTE_SIZE];
                        len_q   <= req_len[arb_idx*BYTE_SIZE +: BYTE_SIZE];
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
                        acc     <= '0;
`endif
                        state   <= ST_OPT;
                    end
                end
                ST_OPT: begin
                    if (tx_ready) begin
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
                        acc   <= csum_xor(acc, opt_q);
`endif
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (tx_ready) begin
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
                        acc   <= csum_xor(acc, len_q);
`endif
                        cnt   <= '0;
                        state <= (len_q == '0) ? ST_TAIL : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_ready) begin
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
                        acc <= csum_xor(acc, cur_data);
`endif
                        cnt <= cnt + 1'b1;
                        if (cnt == len_q - 1'b1)
                            state <= ST_TAIL;
                    end
                end
`ifdef UART_MSG_TX_ARB_CHECKSUM_EN
                ST_CSUM: begin
                    if (tx_ready)
                        state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    last_idx <= gnt_idx;
                    gnt_q    <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_tx_arb.sv
// tb/tb_uart_msg_tx_arb.sv - directed self-checking bench for uart_msg_tx_arb
module tb_uart_msg_tx_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] req_opt;
    logic [31:0] req_len;
    logic [31:0] req_data;
    logic [3:0]  o_gnt;
    logic [3:0]  o_pop;
    logic [3:0]  o_done;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    uart_msg_tx_arb #(.BYTE_SIZE(8), .NUM_REQ(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .req_opt  (req_opt),
        .req_len  (req_len),
        .req_data (req_data),
        .o_gnt    (o_gnt),
        .o_pop    (o_pop),
        .o_done   (o_done),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .o_busy   (o_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},   32'(o_gnt),    32'h0);
        chk({tag, "_pop"},   32'(o_pop),    32'h0);
        chk({tag, "_done"},  32'(o_done),   32'h0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_busy"},  32'(o_busy),   32'h0);
    endtask

    initial begin
        logic [7:0] t3_exp [5];
        logic [7:0] t3_dat [3];
        int n;
        int pops;

        RST = 1'b1; req = '0; req_opt = '0; req_len = '0; req_data = '0; tx_ready = 1'b1;
        @(negedge CLK); #1;
        chk_quiet("rst");
        chk("rst_byte", 32'(tx_byte), 32'h0);

`ifndef UART_MSG_TX_ARB_CHECKSUM_EN
        // single source, len 2
        @(negedge CLK); RST = 1'b0; req = 4'b0001;
        req_opt[7:0] = 8'hA5; req_len[7:0] = 8'd2; req_data[7:0] = 8'h11;
        @(negedge CLK); #1;
        chk("t1_gnt", 32'(o_gnt), 32'h1);
        chk("t1_valid", 32'(tx_valid), 32'h1);
        chk("t1_opt", 32'(tx_byte), 32'hA5);
        chk("t1_pop_opt", 32'(o_pop), 32'h0);
        @(negedge CLK); #1;
        chk("t1_len", 32'(tx_byte), 32'h02);
        @(negedge CLK); #1;
        chk("t1_d0", 32'(tx_byte), 32'h11);
        chk("t1_pop0", 32'(o_pop), 32'h1);
        @(negedge CLK); req_data[7:0] = 8'h22; #1;
        chk("t1_d1", 32'(tx_byte), 32'h22);
        chk("t1_pop1", 32'(o_pop), 32'h1);
        @(negedge CLK); req = 4'b0000; #1;
        chk("t1_done", 32'(o_done), 32'h1);
        chk("t1_done_gnt", 32'(o_gnt), 32'h1);
        chk("t1_done_valid", 32'(tx_valid), 32'h0);
        chk("t1_done_pop", 32'(o_pop), 32'h0);
        @(negedge CLK); #1;
        chk_quiet("t1_idle");

        // all sources, len 0, round robin from a fresh reset
        @(negedge CLK); RST = 1'b1; req = 4'b1111; req_len = '0;
        req_opt = 32'hC3C2C1C0;
        @(negedge CLK); #1;
        chk_quiet("t2_rst");
        @(negedge CLK); RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK); #1;
            chk("t2_gnt", 32'(o_gnt), 32'(4'b0001 << (k % 4)));
            chk("t2_opt", 32'(tx_byte), 32'(8'hC0 + (k % 4)));
            @(negedge CLK); #1;
            chk("t2_len_valid", 32'(tx_valid), 32'h1);
            chk("t2_len", 32'(tx_byte), 32'h00);
            @(negedge CLK); if (k == 4) req = 4'b0000; #1;
            chk("t2_done", 32'(o_done), 32'(4'b0001 << (k % 4)));
            @(negedge CLK); #1;
            chk("t2_idle_busy", 32'(o_busy), 32'h0);
        end

        // source 1, len 3, tx_ready toggling
        t3_exp[0] = 8'h3C; t3_exp[1] = 8'h03; t3_exp[2] = 8'h31; t3_exp[3] = 8'h32; t3_exp[4] = 8'h33;
        t3_dat[0] = 8'h31; t3_dat[1] = 8'h32; t3_dat[2] = 8'h33;
        @(negedge CLK); req = 4'b0010; req_opt[15:8] = 8'h3C; req_len[15:8] = 8'd3;
        n = 0; pops = 0;
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            @(negedge CLK);
            tx_ready = (cyc % 2 == 0);
            if (n >= 2) req_data[15:8] = t3_dat[n-2];
            #1;
            chk("t3_valid", 32'(tx_valid), 32'h1);
            chk("t3_byte", 32'(tx_byte), 32'(t3_exp[n]));
            chk("t3_pop", 32'(o_pop), (tx_ready && n >= 2) ? 32'h2 : 32'h0);
            if (o_pop[1]) pops++;
            if (tx_ready) n++;
        end
        chk("t3_xfers", 32'(n), 32'd5);
        chk("t3_pops", 32'(pops), 32'd3);
        @(negedge CLK); tx_ready = 1'b1; req = 4'b0000; #1;
        chk("t3_done", 32'(o_done), 32'h2);
        @(negedge CLK); #1;
        chk_quiet("t3_idle");

        // source 2 drops req after LEN
        @(negedge CLK); req = 4'b0100; req_opt[23:16] = 8'h77; req_len[23:16] = 8'd2; req_data[23:16] = 8'h41;
        @(negedge CLK); #1;
        chk("t4_gnt", 32'(o_gnt), 32'h4);
        chk("t4_opt", 32'(tx_byte), 32'h77);
        @(negedge CLK); #1;
        chk("t4_len", 32'(tx_byte), 32'h02);
        @(negedge CLK); req = 4'b0000; #1;
        chk("t4_d0", 32'(tx_byte), 32'h41);
        chk("t4_pop0", 32'(o_pop), 32'h4);
        @(negedge CLK); req_data[23:16] = 8'h42; #1;
        chk("t4_d1", 32'(tx_byte), 32'h42);
        chk("t4_pop1", 32'(o_pop), 32'h4);
        @(negedge CLK); #1;
        chk("t4_done", 32'(o_done), 32'h4);
        @(negedge CLK); #1;
        chk_quiet("t4_idle");

        // reset mid-payload abandons the frame
        @(negedge CLK); req = 4'b1000; req_opt[31:24] = 8'h99; req_len[31:24] = 8'd4; req_data[31:24] = 8'h51;
        @(negedge CLK); #1;
        chk("t5_gnt", 32'(o_gnt), 32'h8);
        @(negedge CLK); #1;
        chk("t5_len", 32'(tx_byte), 32'h04);
        @(negedge CLK); #1;
        chk("t5_d0", 32'(tx_byte), 32'h51);
        chk("t5_pop0", 32'(o_pop), 32'h8);
        @(negedge CLK); RST = 1'b1; req_data[31:24] = 8'h52;
        @(negedge CLK); RST = 1'b0; req = 4'b1001; req_opt[7:0] = 8'h5A; req_len[7:0] = 8'd0; #1;
        chk_quiet("t5_rst");
        chk("t5_rst_byte", 32'(tx_byte), 32'h0);
        @(negedge CLK); #1;
        chk("t5_regnt", 32'(o_gnt), 32'h1);
        chk("t5_reopt", 32'(tx_byte), 32'h5A);
        @(negedge CLK); #1;
        chk("t5_relen", 32'(tx_byte), 32'h00);
        @(negedge CLK); req = 4'b0000; #1;
        chk("t5_redone", 32'(o_done), 32'h1);
        @(negedge CLK); #1;
        chk_quiet("t5_idle");
`else
        // checksum frame
        @(negedge CLK); RST = 1'b0; req = 4'b0001;
        req_opt[7:0] = 8'h01; req_len[7:0] = 8'd2; req_data[7:0] = 8'h0F;
        @(negedge CLK); #1;
        chk("cs_gnt", 32'(o_gnt), 32'h1);
        chk("cs_opt", 32'(tx_byte), 32'h01);
        @(negedge CLK); #1;
        chk("cs_len", 32'(tx_byte), 32'h02);
        @(negedge CLK); #1;
        chk("cs_d0", 32'(tx_byte), 32'h0F);
        chk("cs_pop0", 32'(o_pop), 32'h1);
        @(negedge CLK); req_data[7:0] = 8'hF0; #1;
        chk("cs_d1", 32'(tx_byte), 32'hF0);
        chk("cs_pop1", 32'(o_pop), 32'h1);
        @(negedge CLK); #1;
        chk("cs_valid", 32'(tx_valid), 32'h1);
        chk("cs_sum", 32'(tx_byte), 32'hFC);
        chk("cs_sum_pop", 32'(o_pop), 32'h0);
        chk("cs_sum_done", 32'(o_done), 32'h0);
        @(negedge CLK); req = 4'b0000; #1;
        chk("cs_done", 32'(o_done), 32'h1);
        chk("cs_done_valid", 32'(tx_valid), 32'h0);
        @(negedge CLK); #1;
        chk_quiet("cs_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
